// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types and defaults for the GCD requester
package gcd_pkg;
  localparam int GCD_WIDTH = 16;
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, WAIT, CLEAR, OUT} req_state_t;
endpackage

// File: rtl/gcd_req_fifo.sv
// gcd_req_fifo: synchronous operand-pair FIFO with full/empty flags
module gcd_req_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr[AW] != rd_ptr[AW] && wr_ptr[AW-1:0] == rd_ptr[AW-1:0];
  assign pop_data = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk) if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
endmodule

// File: rtl/gcd_requester.sv
// gcd_requester: feeds queued operand pairs to the GCD engine and returns results in order; watchdog with GCD_REQ_TIMEOUT_EN
module gcd_requester import gcd_pkg::*; #(
  parameter int WIDTH = GCD_WIDTH,
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err,
  output logic             eng_start,
  output logic [WIDTH-1:0] eng_data,
  output logic             eng_clr,
  input  logic             eng_done,
  input  logic [WIDTH-1:0] eng_result,
  output logic             busy
);
  req_state_t state, state_d;
  logic [2*WIDTH-1:0] head;
  logic [WIDTH-1:0] head_a, head_b, b_q, b_d, gcd_d, data_d;
  logic full, empty, pop, rdy_en;
  assign {head_a, head_b} = head;
  assign in_ready = rdy_en && !full;
  assign busy = state != IDLE || !empty;
  assign pop = state == IDLE && !empty;
  gcd_req_fifo #(.W(2*WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(in_valid && in_ready),
    .push_data({in_a, in_b}),
    .pop(pop),
    .pop_data(head),
    .full(full),
    .empty(empty)
  );
`ifdef GCD_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer, timer_d;
  logic err_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
      out_err <= 1'b0;
    end else begin
      timer <= timer_d;
      out_err <= err_d;
    end
  end
`else
  assign out_err = 1'b0;
`endif
  always_comb begin
    state_d = state;
    b_d = b_q;
    gcd_d = out_gcd;
`ifdef GCD_REQ_TIMEOUT_EN
    err_d = out_err;
    timer_d = '0;
`endif
    case (state)
      IDLE:
        if (!empty) begin
          b_d = head_b;
          // a zero operand would never let the engine finish, so answer directly
          if (head_a == '0 || head_b == '0) begin
            gcd_d = head_a | head_b;
            state_d = OUT;
          end else state_d = LOAD_A;
        end
      LOAD_A: state_d = LOAD_B;
      LOAD_B: state_d = WAIT;
      WAIT:
        if (eng_done) begin
          gcd_d = eng_result;
          state_d = CLEAR;
        end
`ifdef GCD_REQ_TIMEOUT_EN
        else if (timer == TW'(TIMEOUT - 1)) begin
          gcd_d = '0;
          err_d = 1'b1;
          state_d = CLEAR;
        end else timer_d = timer + 1'b1;
`endif
      CLEAR: state_d = OUT;
      OUT:
        if (out_ready) begin
          state_d = IDLE;
`ifdef GCD_REQ_TIMEOUT_EN
          err_d = 1'b0;
`endif
        end
      default: state_d = IDLE;
    endcase
    data_d = state_d == LOAD_A ? head_a : state_d == LOAD_B ? b_q : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      b_q <= '0;
      out_gcd <= '0;
      out_valid <= 1'b0;
      eng_start <= 1'b0;
      eng_data <= '0;
      eng_clr <= 1'b1;
      rdy_en <= 1'b0;
    end else begin
      state <= state_d;
      b_q <= b_d;
      out_gcd <= gcd_d;
      out_valid <= state_d == OUT;
      eng_start <= state_d == LOAD_A;
      eng_data <= data_d;
      eng_clr <= state_d == CLEAR;
      rdy_en <= 1'b1;
    end
  end
endmodule

// File: tb/tb_gcd_requester.sv
// tb_gcd_requester: scoreboard bench with a behavioural N-cycle GCD engine
module tb_gcd_requester;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1, out_err;
  logic [15:0] in_a = 0, in_b = 0, out_gcd, eng_data, eng_result = 0;
  logic eng_start, eng_clr, eng_done = 0, busy;
  int tests = 0, fails = 0, starts = 0, clrs = 0, lat = 0;
  logic hang = 0;
  logic [16:0] exp_q[$];
  logic [31:0] ops_q[$];
  always #5 clk = ~clk;
  gcd_requester #(.WIDTH(16), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd), .out_err(out_err),
    .eng_start(eng_start), .eng_data(eng_data), .eng_clr(eng_clr), .eng_done(eng_done),
    .eng_result(eng_result), .busy(busy)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [15:0] gcd(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction
  logic [15:0] ea, eres;
  int phase = 0, cnt = 0;
  always @(posedge clk) begin
    if (rst || eng_clr) begin
      phase <= 0;
      eng_done <= 0;
    end else if (eng_start) begin
      ea <= eng_data;
      phase <= 1;
    end else if (phase == 1) begin
      eres <= gcd(ea, eng_data);
      cnt <= lat;
      phase <= 2;
    end else if (phase == 2 && !hang) begin
      if (cnt == 0) begin
        eng_done <= 1;
        eng_result <= eres;
      end else cnt <= cnt - 1;
    end
  end
  logic want_b = 0;
  logic [15:0] exp_b;
  logic hold = 0;
  logic [15:0] hold_g;
  always @(negedge clk) begin
    if (rst) begin
      want_b = 0;
      hold = 0;
    end else begin
      if (eng_start) starts++;
      if (eng_clr) clrs++;
      if (want_b) begin
        chk("eng_data_b", eng_data, exp_b);
        want_b = 0;
      end
      if (eng_start) begin
        if (ops_q.size() == 0) chk("unexpected_start", 1, 0);
        else begin
          chk("eng_data_a", eng_data, ops_q[0][31:16]);
          exp_b = ops_q[0][15:0];
          void'(ops_q.pop_front());
          want_b = 1;
        end
      end
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_gcd", out_gcd, hold_g);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          chk("result_gcd", out_gcd, exp_q[0][15:0]);
          chk("result_err", out_err, exp_q[0][16]);
          void'(exp_q.pop_front());
        end
      end
      hold = out_valid && !out_ready;
      hold_g = out_gcd;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [15:0] g,
                      input logic e, input logic keep);
    int n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1;
    while (!in_ready && n < 300) begin
      tick();
      n++;
    end
    if (!in_ready) chk("push_timeout", 0, 1);
    else begin
      if (keep) exp_q.push_back({e, g});
      if (a != 0 && b != 0) ops_q.push_back({a, b});
    end
    tick();
    in_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy || out_valid) && n < 500) begin
      tick();
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask
  task automatic wait_sig(input string name, input int which);
    int n = 0;
    while (!(which == 0 ? eng_start : out_valid) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk(name, 0, 1);
  endtask
  int s0, c0, k;
  initial begin
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_gcd", out_gcd, 0);
    chk("rst_eng_clr", eng_clr, 1);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    tick();
    chk("ready_after_rst", in_ready, 1);
    chk("clr_after_rst", eng_clr, 0);
    s0 = starts;
    c0 = clrs;
    push(48, 18, 6, 0, 1);
    drain();
    chk("t1_starts", starts - s0, 1);
    chk("t1_clrs", clrs - c0, 1);
    s0 = starts;
    push(0, 7, 7, 0, 1);
    push(0, 0, 0, 0, 1);
    push(9, 0, 9, 0, 1);
    drain();
    chk("t2_no_start", starts - s0, 0);
    out_ready = 0;
    push(48, 18, 6, 0, 1);
    wait_sig("t5_valid_timeout", 1);
    for (int i = 0; i < 10; i++) begin
      chk("t5_valid", out_valid, 1);
      chk("t5_gcd", out_gcd, 6);
      chk("t5_start", eng_start, 0);
      tick();
    end
    push(12, 8, 4, 0, 1);
    push(9, 6, 3, 0, 1);
    push(35, 14, 7, 0, 1);
    push(17, 5, 1, 0, 1);
    chk("t3_full_blocks", in_ready, 0);
    fork
      push(100, 75, 25, 0, 1);
      begin
        repeat (3) tick();
        out_ready = 1;
      end
    join
    drain();
    lat = 20;
    push(48, 18, 6, 0, 0);
    wait_sig("t4_start_timeout", 0);
    repeat (4) tick();
    rst = 1;
    tick();
    chk("t4_out_valid", out_valid, 0);
    chk("t4_out_gcd", out_gcd, 0);
    chk("t4_eng_clr", eng_clr, 1);
    chk("t4_eng_start", eng_start, 0);
    chk("t4_eng_data", eng_data, 0);
    chk("t4_in_ready", in_ready, 0);
    chk("t4_busy", busy, 0);
    chk("t4_out_err", out_err, 0);
    rst = 0;
    tick();
    chk("t4_ready_back", in_ready, 1);
    lat = 0;
    push(21, 14, 7, 0, 1);
    drain();
`ifdef GCD_REQ_TIMEOUT_EN
    hang = 1;
    push(48, 18, 0, 1, 1);
    wait_sig("t6_start_timeout", 0);
    k = 0;
    while (!out_valid && k < 60) begin
      tick();
      k++;
    end
    chk("t6_latency", k, 19);
    drain();
    hang = 0;
    push(10, 4, 2, 0, 1);
    drain();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
